shift_pipeline: RTL and testbench
=================================

SHIFT_PIPELINE -- requirements
Module: shift_pipeline

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data width of each stage in bits (legal range 1 or greater).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of register stages (legal range 1 or greater).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mode  input  2  operation select: 00 hold, 01 shift, 10 rotate, 11 parallel load.
REQ-006 SHALL have port clear  input  1  synchronous invalidate of all stages.
REQ-007 SHALL have port din  input  WIDTH  serial data into stage 0.
REQ-008 SHALL have port din_valid  input  1  qualifies din in shift mode.
REQ-009 SHALL have port load_data  input  DEPTH*WIDTH  parallel load data; slice i, i.e. bits [i*WIDTH +: WIDTH], goes to stage i.
REQ-010 SHALL have port taps  output  DEPTH*WIDTH  all stage contents; slice i = stage i.
REQ-011 SHALL have port dout  output  WIDTH  stage DEPTH-1 data.
REQ-012 SHALL have port dout_valid  output  1  valid bit of stage DEPTH-1.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 Each stage SHALL hold a WIDTH-bit data register and a 1-bit valid flag, all updated with non-blocking semantics, so that every stage samples pre-edge values of its neighbours.
REQ-015 Hold (00): data, valid and count unchanged.
REQ-016 Shift (01): stage0 <= din, valid0 <= din_valid; stage i <= stage i-1 and valid i <= valid i-1, for i=1..DEPTH-1; the contents of stage DEPTH-1 are discarded.
REQ-017 Shift latency: a word presented on din with mode=01 SHALL appear on dout after exactly DEPTH consecutive shift edges.
REQ-018 Shift with din_valid=0 SHALL still move data; stage 0 receives din with valid0=0, creating a bubble.
REQ-019 Rotate (10): stage0 <= stage DEPTH-1, stage i <= stage i-1; valid flags rotate identically; count unchanged.
REQ-020 Parallel load (11): stage i <= load_data slice i for all i; all valid flags set to 1; count <= DEPTH.
REQ-021 DEPTH=1 boundaries: rotate SHALL leave stage 0 unchanged; shift SHALL replace stage 0.
REQ-022 clear=1 SHALL set all valid flags to 0 and count to 0 on that edge, leaving data registers unchanged, and SHALL take priority over every mode.
REQ-023 count SHALL equal the population count of the valid flags after every edge; it is registered, never combinational from inputs, and never exceeds DEPTH.
REQ-024 Shift with the pipeline full and din_valid=1: count SHALL stay DEPTH as the oldest word drops out.
REQ-025 Shift with the pipeline full and din_valid=0: count SHALL decrement by 1.
REQ-026 dout, dout_valid and taps SHALL be driven directly from registers, with no combinational path from any input.
REQ-027 mode SHALL be sampled only at the rising edge; changes between edges have no effect.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force all data registers to 0, all valid flags to 0, and count to 0.
REQ-029 Reset asserted mid-shift or mid-load SHALL abort the operation; no partial update survives.
REQ-030 After rst_n deasserts, the first rising edge SHALL perform normal operation.

Verification
REQ-031 WIDTH=32, DEPTH=4, reset then shift din=1,2,3,4 with din_valid=1 -> after edge 4: taps={s3..s0}={1,2,3,4}, dout=1, dout_valid=1, count=4.
REQ-032 From the REQ-031 state, rotate 1 edge -> stages {s0..s3}={1,4,3,2}, dout=2, count=4; rotate 3 more edges -> original state restored.
REQ-033 Load load_data slices {10,20,30,40}, then shift with din_valid=0 for 4 edges -> dout sequence 30,20,10, then a bubble with dout_valid=0, and count=3,2,1,0.
REQ-034 Full pipeline with mode=11 and clear=1 on the same edge -> count=0, all valid flags 0, data unchanged from before the edge.
REQ-035 rst_n pulsed low between edges during shift traffic -> all outputs 0 before the next edge; the next shift loads din into s0 with count=1.
REQ-036 DEPTH=1 instance: shift 7, then rotate -> dout=7 held, count=1; shift with din_valid=0 -> count=0.

Source files
------------

// File: rtl/shift_pipeline.sv
// Multi-mode register pipeline: hold, shift, rotate and parallel load of DEPTH stages,
// each carrying a data word and a valid flag, with a registered valid-stage count.
module shift_pipeline #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic [1:0]                   mode,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             din,
    input  logic                         din_valid,
    input  logic [DEPTH*WIDTH-1:0]       load_data,
    output logic [DEPTH*WIDTH-1:0]       taps,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] ModeHold   = 2'b00;
    localparam logic [1:0] ModeShift  = 2'b01;
    localparam logic [1:0] ModeRotate = 2'b10;
    localparam logic [1:0] ModeLoad   = 2'b11;

    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            r_valid;
    logic [CW-1:0]               r_count;

    logic [DEPTH-1:0][WIDTH-1:0] w_data_d;
    logic [DEPTH-1:0]            w_valid_d;
    logic [CW-1:0]               w_count_d;

    always_comb begin
        w_data_d  = r_data;
        w_valid_d = r_valid;
        case (mode)
            ModeHold: begin
                w_data_d  = r_data;
                w_valid_d = r_valid;
            end
            ModeShift: begin
                w_data_d[0]  = din;
                w_valid_d[0] = din_valid;
                for (int i = 1; i < DEPTH; i++) begin
                    w_data_d[i]  = r_data[i-1];
                    w_valid_d[i] = r_valid[i-1];
                end
            end
            ModeRotate: begin
                w_data_d[0]  = r_data[DEPTH-1];
                w_valid_d[0] = r_valid[DEPTH-1];
                for (int i = 1; i < DEPTH; i++) begin
                    w_data_d[i]  = r_data[i-1];
                    w_valid_d[i] = r_valid[i-1];
                end
            end
            ModeLoad: begin
                for (int i = 0; i < DEPTH; i++) begin
                    w_data_d[i] = load_data[i*WIDTH +: WIDTH];
                end
                w_valid_d = '1;
            end
            default: begin
                w_data_d  = r_data;
                w_valid_d = r_valid;
            end
        endcase

        // clear wins over every mode and only invalidates; data words are kept
        if (clear) begin
            w_data_d  = r_data;
            w_valid_d = '0;
        end
    end

    always_comb begin
        w_count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count_d = w_count_d + CW'(w_valid_d[i]);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_data  <= w_data_d;
            r_valid <= w_valid_d;
            r_count <= w_count_d;
        end
    end

    assign taps       = r_data;
    assign dout       = r_data[DEPTH-1];
    assign dout_valid = r_valid[DEPTH-1];
    assign count      = r_count;

endmodule

// File: tb/tb_shift_pipeline.sv
// Self-checking bench for shift_pipeline: a reference model pushes expected state per edge
// into a scoreboard queue; directed checks cover the worked examples and DEPTH=1 corners.
module tb_shift_pipeline;

    logic         clock;
    logic         rst_n;
    logic [1:0]   mode;
    logic         clear;
    logic [31:0]  din;
    logic         din_valid;
    logic [127:0] load_data;
    logic [127:0] taps;
    logic [31:0]  dout;
    logic         dout_valid;
    logic [2:0]   count;

    logic [1:0]   mode1;
    logic         clear1;
    logic [31:0]  din1;
    logic         din_valid1;
    logic [31:0]  load_data1;
    logic [31:0]  taps1;
    logic [31:0]  dout1;
    logic         dout_valid1;
    logic [0:0]   count1;

    shift_pipeline #(.WIDTH(32), .DEPTH(4)) u_dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .mode       (mode),
        .clear      (clear),
        .din        (din),
        .din_valid  (din_valid),
        .load_data  (load_data),
        .taps       (taps),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count)
    );

    shift_pipeline #(.WIDTH(32), .DEPTH(1)) u_dut1 (
        .clock      (clock),
        .rst_n      (rst_n),
        .mode       (mode1),
        .clear      (clear1),
        .din        (din1),
        .din_valid  (din_valid1),
        .load_data  (load_data1),
        .taps       (taps1),
        .dout       (dout1),
        .dout_valid (dout_valid1),
        .count      (count1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [127:0] taps;
        logic         dv;
        logic [2:0]   cnt;
    } exp_t;

    exp_t             sb_q[$];
    logic [3:0][31:0] m_data;
    logic [3:0]       m_valid;
    int               n_cmp;
    int               n_err;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one edge of stimulus, advance the model, then compare after the edge.
    task automatic step(input logic [1:0] md, input logic clr, input logic [31:0] d,
                        input logic dv, input logic [127:0] ld);
        exp_t e;
        exp_t got;
        @(negedge clock);
        mode      = md;
        clear     = clr;
        din       = d;
        din_valid = dv;
        load_data = ld;
        if (clr) begin
            m_valid = '0;
        end else begin
            case (md)
                2'b01: begin
                    m_data  = {m_data[2:0], d};
                    m_valid = {m_valid[2:0], dv};
                end
                2'b10: begin
                    m_data  = {m_data[2:0], m_data[3]};
                    m_valid = {m_valid[2:0], m_valid[3]};
                end
                2'b11: begin
                    m_data  = ld;
                    m_valid = 4'hf;
                end
                default: ;
            endcase
        end
        e.taps = m_data;
        e.dv   = m_valid[3];
        e.cnt  = 3'($countones(m_valid));
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 128'd1, 128'd0);
        end else begin
            got = sb_q.pop_front();
            check_val("sb_taps", taps, got.taps);
            check_val("sb_dout", {96'd0, dout}, {96'd0, got.taps[127:96]});
            check_val("sb_dout_valid", {127'd0, dout_valid}, {127'd0, got.dv});
            check_val("sb_count", {125'd0, count}, {125'd0, got.cnt});
        end
        mode = 2'b00;
        clear = 1'b0;
    endtask

    initial begin
        logic [127:0] snap;
        n_cmp      = 0;
        n_err      = 0;
        m_data     = '0;
        m_valid    = '0;
        rst_n      = 1'b1;
        mode       = 2'b00;
        clear      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        load_data  = '0;
        mode1      = 2'b00;
        clear1     = 1'b0;
        din1       = '0;
        din_valid1 = 1'b0;
        load_data1 = '0;

        #1 rst_n = 1'b0;
        #2;
        check_val("rst_taps", taps, 128'd0);
        check_val("rst_dout_valid", {127'd0, dout_valid}, 128'd0);
        check_val("rst_count", {125'd0, count}, 128'd0);
        check_val("rst1_count", {127'd0, count1}, 128'd0);
        @(negedge clock);
        rst_n = 1'b1;

        // Fill with 1..4
        for (int i = 1; i <= 4; i++) step(2'b01, 1'b0, 32'(i), 1'b1, '0);
        check_val("fill_taps", taps, {32'd1, 32'd2, 32'd3, 32'd4});
        check_val("fill_dout", {96'd0, dout}, 128'd1);
        check_val("fill_count", {125'd0, count}, 128'd4);

        step(2'b10, 1'b0, 32'hbad, 1'b0, '0);
        check_val("rot1_taps", taps, {32'd2, 32'd3, 32'd4, 32'd1});
        check_val("rot1_dout", {96'd0, dout}, 128'd2);
        for (int i = 0; i < 3; i++) step(2'b10, 1'b0, 32'hbad, 1'b0, '0);
        check_val("rot4_taps", taps, {32'd1, 32'd2, 32'd3, 32'd4});

        step(2'b00, 1'b0, 32'h1234, 1'b1, {4{32'hffff}});
        check_val("hold_taps", taps, {32'd1, 32'd2, 32'd3, 32'd4});

        // Load then drain with bubbles
        step(2'b11, 1'b0, 32'h0, 1'b0, {32'd40, 32'd30, 32'd20, 32'd10});
        check_val("load_dout", {96'd0, dout}, 128'd40);
        step(2'b01, 1'b0, 32'hdead, 1'b0, '0);
        check_val("drain1", {92'd0, count, dout, dout_valid}, {92'd0, 3'd3, 32'd30, 1'b1});
        step(2'b01, 1'b0, 32'hdead, 1'b0, '0);
        check_val("drain2", {92'd0, count, dout, dout_valid}, {92'd0, 3'd2, 32'd20, 1'b1});
        step(2'b01, 1'b0, 32'hdead, 1'b0, '0);
        check_val("drain3", {92'd0, count, dout, dout_valid}, {92'd0, 3'd1, 32'd10, 1'b1});
        step(2'b01, 1'b0, 32'hdead, 1'b0, '0);
        check_val("drain4", {124'd0, count, dout_valid}, 128'd0);

        // Full pipeline: valid shift keeps count, bubble shift drops it
        step(2'b11, 1'b0, 32'h0, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1});
        step(2'b01, 1'b0, 32'd5, 1'b1, '0);
        check_val("full_valid_shift", {125'd0, count}, 128'd4);
        step(2'b01, 1'b0, 32'd6, 1'b0, '0);
        check_val("full_bubble_shift", {125'd0, count}, 128'd3);

        // Load together with clear: invalidate only
        step(2'b11, 1'b0, 32'h0, 1'b0, {32'ha, 32'hb, 32'hc, 32'hd});
        snap = taps;
        step(2'b11, 1'b1, 32'h0, 1'b0, {4{32'h5555}});
        check_val("clr_load_count", {125'd0, count}, 128'd0);
        check_val("clr_load_taps", taps, snap);
        check_val("clr_load_dv", {127'd0, dout_valid}, 128'd0);

        for (int i = 0; i < 40; i++) begin
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), $urandom,
                 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
        end

        // Asynchronous reset between edges during shift traffic
        step(2'b01, 1'b0, 32'h77, 1'b1, '0);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_taps", taps, 128'd0);
        check_val("mid_rst_out", {124'd0, count, dout_valid}, 128'd0);
        m_data  = '0;
        m_valid = '0;
        #1 rst_n = 1'b1;
        step(2'b01, 1'b0, 32'h55, 1'b1, '0);
        check_val("post_rst_taps", taps, 128'h55);
        check_val("post_rst_count", {125'd0, count}, 128'd1);

        // DEPTH=1 corners
        @(negedge clock);
        mode1 = 2'b01; din1 = 32'd7; din_valid1 = 1'b1;
        @(posedge clock); #1;
        check_val("d1_shift", {95'd0, count1, dout1, dout_valid1}, {95'd0, 1'b1, 32'd7, 1'b1});
        @(negedge clock);
        mode1 = 2'b10; din1 = 32'd9; din_valid1 = 1'b0;
        @(posedge clock); #1;
        check_val("d1_rotate", {95'd0, count1, dout1, dout_valid1}, {95'd0, 1'b1, 32'd7, 1'b1});
        @(negedge clock);
        mode1 = 2'b01;
        @(posedge clock); #1;
        check_val("d1_bubble", {95'd0, count1, dout1, dout_valid1}, {95'd0, 1'b0, 32'd9, 1'b0});
        @(negedge clock);
        mode1 = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
